// File: rtl/int_pipe_ctrl.sv
// Pipeline sequencer: load-use stalls, interrupt accept/drain/vector, ERET return.
module int_pipe_ctrl #(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0008,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  exe_rn,
  input  logic        exe_wreg,
  input  logic        exe_m2reg,
  input  logic [31:0] id_pc,
  input  logic        id_in_dslot,
  input  logic        id_eret,
  input  logic        intr,
  input  logic        ie,
  output logic        stall,
  output logic        id_flush,
  output logic        if_flush,
  output logic [1:0]  pc_sel,
  output logic [31:0] epc,
  output logic        ie_clr,
  output logic        ie_set,
  output logic        busy
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

  localparam logic [1:0] PC_NORMAL = 2'b00;
  localparam logic [1:0] PC_VECTOR = 2'b01;
  localparam logic [1:0] PC_EPC    = 2'b10;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    VECTOR = 2'b10
  } state_t;

  // Elaboration-time parameter sanity: counter range and word-aligned vector.
  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 7) begin : g_bad_drain
    $error("int_pipe_ctrl: DRAIN_CYCLES must be 1..7");
  end
  if (VECTOR_ADDR[1:0] != 2'b00) begin : g_bad_vector
    $error("int_pipe_ctrl: VECTOR_ADDR must be word aligned");
  end

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0]      epc_d;
  logic             pend, pend_d;
  logic             intr_q;
  logic             intr_edge;
  logic             lu;
  logic             acc;

  // Load-use hazard: EXE load result needed by ID, which forwarding cannot supply.
  assign lu = exe_wreg & exe_m2reg & (exe_rn != 5'd0) &
              ((id_use_rs & (exe_rn == id_rs)) | (id_use_rt & (exe_rn == id_rt)));

  // Interrupt is taken only at a clean instruction boundary in RUN.
  assign intr_edge = intr & ~intr_q;
  assign acc       = (state == RUN) & pend & ie & ~lu & ~id_in_dslot & ~id_eret;
  assign busy      = (state != RUN);

  // A fresh edge arriving in the accept cycle survives the clear.
  assign pend_d = acc ? intr_edge : (pend | intr_edge);

  // State, counter, saved PC and interrupt-edge tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      cnt    <= '0;
      epc    <= '0;
      pend   <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      epc    <= epc_d;
      pend   <= pend_d;
      intr_q <= intr;
    end
  end

  // Next-state and pipeline control decode.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    epc_d    = epc;
    stall    = 1'b0;
    id_flush = 1'b0;
    if_flush = 1'b0;
    pc_sel   = PC_NORMAL;
    ie_clr   = 1'b0;
    ie_set   = 1'b0;
    case (state)
      RUN: begin
        if (lu) begin
          stall    = 1'b1;
          id_flush = 1'b1;
        end else if (id_eret) begin
          pc_sel   = PC_EPC;
          if_flush = 1'b1;
          id_flush = 1'b1;
          ie_set   = 1'b1;
        end else if (acc) begin
          stall    = 1'b1;
          id_flush = 1'b1;
          epc_d    = id_pc;
          cnt_d    = CNT_INIT;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        stall    = 1'b1;
        id_flush = 1'b1;
        if (cnt == '0) begin
          state_d = VECTOR;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      VECTOR: begin
        pc_sel   = PC_VECTOR;
        if_flush = 1'b1;
        id_flush = 1'b1;
        ie_clr   = 1'b1;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_int_pipe_ctrl.sv
// Directed self-checking bench for int_pipe_ctrl.
module tb_int_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, exe_rn;
  logic        id_use_rs, id_use_rt, exe_wreg, exe_m2reg;
  logic [31:0] id_pc;
  logic        id_in_dslot, id_eret, intr, ie;
  logic        stall, id_flush, if_flush, ie_clr, ie_set, busy;
  logic [1:0]  pc_sel;
  logic [31:0] epc;

  int checks   = 0;
  int failures = 0;

  int_pipe_ctrl #(.VECTOR_ADDR(32'h0000_0008), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .exe_rn(exe_rn), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg),
    .id_pc(id_pc), .id_in_dslot(id_in_dslot), .id_eret(id_eret),
    .intr(intr), .ie(ie),
    .stall(stall), .id_flush(id_flush), .if_flush(if_flush), .pc_sel(pc_sel),
    .epc(epc), .ie_clr(ie_clr), .ie_set(ie_set), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    exe_rn = 5'd0; exe_wreg = 1'b0; exe_m2reg = 1'b0;
    id_pc = 32'h0; id_in_dslot = 1'b0; id_eret = 1'b0; intr = 1'b0; ie = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step(); step();
    #1;
    checks++; if ({stall, id_flush, if_flush, ie_clr, ie_set, busy} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000000", {stall, id_flush, if_flush, ie_clr, ie_set, busy}); end
    checks++; if (pc_sel !== 2'b00) begin failures++; $display("FAIL reset_pc_sel got=%b exp=00", pc_sel); end
    checks++; if (epc !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=0", epc); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_load_use();
    exe_wreg = 1'b1; exe_m2reg = 1'b1; exe_rn = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    #1;
    checks++; if ({stall, id_flush} !== 2'b11) begin failures++; $display("FAIL lu_rs got=%b exp=11", {stall, id_flush}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL lu_busy got=%b exp=0", busy); end
    exe_rn = 5'd0; id_rs = 5'd0;
    #1;
    checks++; if ({stall, id_flush} !== 2'b00) begin failures++; $display("FAIL lu_r0 got=%b exp=00", {stall, id_flush}); end
    exe_rn = 5'd9; id_rs = 5'd1; id_rt = 5'd9; id_use_rt = 1'b1;
    #1;
    checks++; if ({stall, id_flush} !== 2'b11) begin failures++; $display("FAIL lu_rt got=%b exp=11", {stall, id_flush}); end
    id_use_rt = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_unused_rt got=%b exp=0", stall); end
    id_use_rt = 1'b1; exe_m2reg = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_not_load got=%b exp=0", stall); end
    idle_inputs();
    step();
  endtask

  task automatic test_interrupt();
    ie = 1'b1; id_pc = 32'h40; intr = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL intr_no_early_acc got=%b exp=0", stall); end
    step();
    checks++; if ({stall, id_flush, busy} !== 3'b110) begin
      failures++; $display("FAIL intr_accept got=%b exp=110", {stall, id_flush, busy}); end
    step();
    id_pc = 32'h99;
    #1;
    checks++; if (epc !== 32'h40) begin failures++; $display("FAIL intr_epc got=%h exp=40", epc); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      checks++; if ({busy, stall, id_flush, pc_sel} !== 5'b11100) begin
        failures++; $display("FAIL intr_drain%0d got=%b exp=11100", i, {busy, stall, id_flush, pc_sel}); end
    end
    step();
    checks++; if ({pc_sel, ie_clr, if_flush, id_flush, stall, busy} !== 7'b0111101) begin
      failures++; $display("FAIL intr_vector got=%b exp=0111101", {pc_sel, ie_clr, if_flush, id_flush, stall, busy}); end
    step();
    checks++; if ({busy, stall, pc_sel, ie_clr} !== 5'b0) begin
      failures++; $display("FAIL intr_back_run got=%b exp=00000", {busy, stall, pc_sel, ie_clr}); end
    step();
    checks++; if ({busy, stall} !== 2'b00) begin failures++; $display("FAIL intr_pend_cleared got=%b exp=00", {busy, stall}); end
    checks++; if (epc !== 32'h40) begin failures++; $display("FAIL intr_epc_hold got=%h exp=40", epc); end
    idle_inputs();
    step();
  endtask

  task automatic test_eret();
    id_eret = 1'b1;
    #1;
    checks++; if ({pc_sel, ie_set, if_flush, id_flush, stall, ie_clr} !== 7'b1011100) begin
      failures++; $display("FAIL eret_ctrl got=%b exp=1011100", {pc_sel, ie_set, if_flush, id_flush, stall, ie_clr}); end
    checks++; if (epc !== 32'h40) begin failures++; $display("FAIL eret_epc got=%h exp=40", epc); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL eret_state got=%b exp=0", busy); end
    exe_wreg = 1'b1; exe_m2reg = 1'b1; exe_rn = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
    #1;
    checks++; if ({stall, pc_sel, ie_set} !== 4'b1000) begin
      failures++; $display("FAIL eret_lu_prio got=%b exp=1000", {stall, pc_sel, ie_set}); end
    idle_inputs();
    step();
  endtask

  task automatic finish_drain(input logic [31:0] exp_epc, input string tag);
    step();
    checks++; if ({busy, epc} !== {1'b1, exp_epc}) begin
      failures++; $display("FAIL %s_drain got=%b/%h exp=1/%h", tag, busy, epc, exp_epc); end
    step(); step(); step();
    checks++; if (pc_sel !== 2'b01) begin failures++; $display("FAIL %s_vector got=%b exp=01", tag, pc_sel); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_run got=%b exp=0", tag, busy); end
  endtask

  task automatic test_ie_masked();
    ie = 1'b0; intr = 1'b1; id_pc = 32'h80;
    step();
    intr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if ({stall, busy} !== 2'b00) begin
        failures++; $display("FAIL mask_no_acc%0d got=%b exp=00", i, {stall, busy}); end
    end
    ie = 1'b1;
    #1;
    checks++; if ({stall, id_flush} !== 2'b11) begin failures++; $display("FAIL mask_acc_on_ie got=%b exp=11", {stall, id_flush}); end
    finish_drain(32'h80, "mask");
    idle_inputs();
    step();
  endtask

  task automatic test_blocked();
    ie = 1'b1; id_in_dslot = 1'b1; id_pc = 32'hC0; intr = 1'b1;
    step();
    intr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({stall, busy} !== 2'b00) begin failures++; $display("FAIL dslot_block%0d got=%b exp=00", i, {stall, busy}); end
      step();
    end
    id_in_dslot = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL dslot_release got=%b exp=1", stall); end
    finish_drain(32'hC0, "dslot");
    exe_wreg = 1'b1; exe_m2reg = 1'b1; exe_rn = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1;
    id_pc = 32'hD0; intr = 1'b1;
    step();
    intr = 1'b0;
    step(); step();
    checks++; if ({busy, stall, epc} !== {2'b01, 32'hC0}) begin
      failures++; $display("FAIL lu_block got=%b/%h exp=01/c0", {busy, stall}, epc); end
    exe_rn = 5'd8;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_release got=%b exp=1", stall); end
    finish_drain(32'hD0, "lu");
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_drain();
    ie = 1'b1; id_pc = 32'h44; intr = 1'b1;
    step();
    intr = 1'b0;
    step();
    intr = 1'b1;
    step();
    #3;
    intr = 1'b0; rst = 1'b1;
    #1;
    checks++; if ({busy, stall, id_flush, pc_sel} !== 5'b0) begin
      failures++; $display("FAIL rst_drain_ctrl got=%b exp=00000", {busy, stall, id_flush, pc_sel}); end
    checks++; if (epc !== 32'h0) begin failures++; $display("FAIL rst_drain_epc got=%h exp=0", epc); end
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({stall, busy} !== 2'b00) begin failures++; $display("FAIL rst_pend_cleared%0d got=%b exp=00", i, {stall, busy}); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_interrupt();
    test_eret();
    test_ie_masked();
    test_blocked();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
